// File: rtl/regfile_dbg_ctrl_rv32i_pkg.sv
// ---------------------------------------------------------------------------
// regfile_dbg_ctrl_rv32i_pkg
// Shared definitions for the RV32I register-file debug controller:
//   - architectural sizes (XLEN, REG_AW, NUM_REGS)
//   - host command opcodes (cmd_op_e)
//   - controller state encoding (state_e)
//   - response record carried through the response buffer (rsp_entry_t)
// ---------------------------------------------------------------------------
package regfile_dbg_ctrl_rv32i_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_DUMP  = 2'b10,
      OP_CLEAR = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_DUMP_RD,
      S_DUMP_DRAIN,
      S_CLR,
      S_RSP
   } state_e;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
      logic              last;
   } rsp_entry_t;

endpackage

// File: rtl/regfile_dbg_ctrl_rv32i_rspbuf.sv
// ---------------------------------------------------------------------------
// regfile_dbg_rspbuf
// In-order response buffer with a one- or two-entry parallel load and a
// valid/ready output stream.
//   clock, reset      : clock, asynchronous active-high reset
//   load_i            : load load0_i (and load1_i when load_two_i) this cycle
//   load_two_i        : load both entries, load0_i first in order
//   load0_i, load1_i  : entries to load
//   valid_o / ready_i : output handshake, head_o is the oldest entry
//   count_o           : number of valid entries
// The owner only loads when the buffer is empty, so load takes priority and
// never collides with a pop.
// ---------------------------------------------------------------------------
module regfile_dbg_rspbuf
   import regfile_dbg_ctrl_rv32i_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       load_i,
   input  logic                       load_two_i,
   input  rsp_entry_t                 load0_i,
   input  rsp_entry_t                 load1_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output rsp_entry_t                 head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   rsp_entry_t       ent_q [DEPTH];
   rsp_entry_t       ent_d [DEPTH];
   logic [CW-1:0]    cnt_q, cnt_d;

   assign valid_o = (cnt_q != '0);
   assign head_o  = ent_q[0];
   assign count_o = cnt_q;

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      if (load_i) begin
         ent_d[0] = load0_i;
         ent_d[1] = load_two_i ? load1_i : '0;
         cnt_d    = load_two_i ? CW'(2) : CW'(1);
      end else if (valid_o && ready_i) begin
         ent_d[0] = ent_q[1];
         ent_d[1] = '0;
         cnt_d    = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/regfile_dbg_ctrl_rv32i.sv
// ---------------------------------------------------------------------------
// regfile_dbg_ctrl_rv32i
// Debug-side initiator for the RV32I 32x32 register file. Accepts WRITE,
// READ, DUMP (inclusive range) and CLEAR (x1..x31) commands, sequences the
// register-file ports and returns results on a valid/ready response stream.
//   clock, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op, cmd_addr,
//                           cmd_addr_end, cmd_wdata describe the command
//   rsp_valid/rsp_ready   : response handshake; rsp_addr, rsp_data, rsp_last
//   busy                  : command in progress, regfile owned
//   rf_rdwrite, rf_rd_addr, rf_rd_in : regfile write port
//   rf_rs1_addr/rf_rs1, rf_rs2_addr/rf_rs2 : regfile read ports
// Optional macro REGFILE_DBG_X0_CHECK_EN adds the sticky x0_err output,
// set when a captured read of x0 returns nonzero.
// ---------------------------------------------------------------------------
module regfile_dbg_ctrl_rv32i
   import regfile_dbg_ctrl_rv32i_pkg::*;
#(
   parameter int unsigned DUMP_BUF_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_addr,
   input  logic [REG_AW-1:0] cmd_addr_end,
   input  logic [XLEN-1:0]   cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [REG_AW-1:0] rsp_addr,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic              rf_rdwrite,
   output logic [REG_AW-1:0] rf_rd_addr,
   output logic [XLEN-1:0]   rf_rd_in,
   output logic [REG_AW-1:0] rf_rs1_addr,
   output logic [REG_AW-1:0] rf_rs2_addr,
   input  logic [XLEN-1:0]   rf_rs1,
   input  logic [XLEN-1:0]   rf_rs2
`ifdef REGFILE_DBG_X0_CHECK_EN
   ,
   output logic              x0_err
`endif
);

   state_e            state_q, state_d;
   logic [REG_AW-1:0] addr_q, addr_d;     // target / current pair start / clear index
   logic [REG_AW-1:0] end_q, end_d;       // effective dump end
   logic [REG_AW-1:0] rs1_q, rs1_d;
   logic [REG_AW-1:0] rs2_q, rs2_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic              buf_load, buf_two, buf_valid;
   rsp_entry_t        ld0, ld1, head;
   logic [$clog2(DUMP_BUF_DEPTH+1)-1:0] buf_cnt;

   logic              rsp_fire;
   logic [REG_AW-1:0] eff_end;
   logic [REG_AW-1:0] next_a;

   assign rsp_fire = buf_valid && rsp_ready;
   // Only used once addr_q+1 < end_q <= 31, so the +2 cannot wrap.
   assign next_a   = addr_q + REG_AW'(2);
   assign eff_end  = (cmd_addr_end < cmd_addr) ? cmd_addr : cmd_addr_end;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      end_d    = end_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      wdata_d  = wdata_q;
      buf_load = 1'b0;
      buf_two  = 1'b0;
      ld0      = '0;
      ld1      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               unique case (cmd_op_e'(cmd_op))
                  OP_WRITE: state_d = S_WR;
                  OP_READ: begin
                     rs1_d   = cmd_addr;
                     state_d = S_RD;
                  end
                  OP_DUMP: begin
                     end_d   = eff_end;
                     rs1_d   = cmd_addr;
                     rs2_d   = (cmd_addr == eff_end) ? cmd_addr : cmd_addr + REG_AW'(1);
                     state_d = S_DUMP_RD;
                  end
                  default: begin
                     addr_d  = REG_AW'(1);
                     state_d = S_CLR;
                  end
               endcase
            end
         end
         S_WR: begin
            buf_load = 1'b1;
            ld0      = '{addr: addr_q, data: (addr_q == '0) ? '0 : wdata_q, last: 1'b1};
            state_d  = S_RSP;
         end
         S_RD: begin
            buf_load = 1'b1;
            ld0      = '{addr: addr_q, data: rf_rs1, last: 1'b1};
            state_d  = S_RSP;
         end
         S_DUMP_RD: begin
            buf_load = 1'b1;
            buf_two  = (addr_q != end_q);
            ld0      = '{addr: addr_q, data: rf_rs1, last: (addr_q == end_q)};
            ld1      = '{addr: addr_q + REG_AW'(1), data: rf_rs2,
                         last: (addr_q + REG_AW'(1) == end_q)};
            state_d  = S_DUMP_DRAIN;
         end
         S_DUMP_DRAIN: begin
            // Issue the next pair on the same edge the final buffered entry
            // leaves, so the read addresses are ready in the DUMP_RD cycle.
            if (rsp_fire && (buf_cnt == 1)) begin
               if (head.last) begin
                  state_d = S_IDLE;
               end else begin
                  addr_d  = next_a;
                  rs1_d   = next_a;
                  rs2_d   = (next_a == end_q) ? next_a : next_a + REG_AW'(1);
                  state_d = S_DUMP_RD;
               end
            end
         end
         S_CLR: begin
            if (addr_q == REG_AW'(NUM_REGS - 1)) begin
               buf_load = 1'b1;
               ld0      = '{addr: addr_q, data: '0, last: 1'b1};
               state_d  = S_RSP;
            end else begin
               addr_d = addr_q + REG_AW'(1);
            end
         end
         S_RSP: begin
            if (rsp_fire && head.last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         end_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         wdata_q <= wdata_d;
      end
   end

   regfile_dbg_rspbuf #(.DEPTH(DUMP_BUF_DEPTH)) u_rspbuf (
      .clock      (clock),
      .reset      (reset),
      .load_i     (buf_load),
      .load_two_i (buf_two),
      .load0_i    (ld0),
      .load1_i    (ld1),
      .valid_o    (buf_valid),
      .ready_i    (rsp_ready),
      .head_o     (head),
      .count_o    (buf_cnt)
   );

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign rsp_valid   = buf_valid;
   assign rsp_addr    = head.addr;
   assign rsp_data    = head.data;
   assign rsp_last    = head.last;
   // Write enable is decoded from state so an async reset removes it at once.
   assign rf_rdwrite  = ((state_q == S_WR) && (addr_q != '0)) || (state_q == S_CLR);
   assign rf_rd_addr  = addr_q;
   assign rf_rd_in    = (state_q == S_WR) ? wdata_q : '0;
   assign rf_rs1_addr = rs1_q;
   assign rf_rs2_addr = rs2_q;

`ifdef REGFILE_DBG_X0_CHECK_EN
   logic x0_err_q, x0_err_d;

   always_comb begin
      x0_err_d = x0_err_q;
      if (((state_q == S_RD) || (state_q == S_DUMP_RD)) && (addr_q == '0) && (rf_rs1 != '0))
         x0_err_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) x0_err_q <= 1'b0;
      else       x0_err_q <= x0_err_d;
   end

   assign x0_err = x0_err_q;
`endif

endmodule

// File: tb/tb_regfile_dbg_ctrl_rv32i.sv
module tb_regfile_dbg_ctrl_rv32i;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_addr = 5'd0;
   logic [4:0]  cmd_addr_end = 5'd0;
   logic [31:0] cmd_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [4:0]  rsp_addr;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        busy;
   logic        rf_rdwrite;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_in;
   logic [4:0]  rf_rs1_addr;
   logic [4:0]  rf_rs2_addr;
   logic [31:0] rf_rs1 = 32'd0;
   logic [31:0] rf_rs2 = 32'd0;
`ifdef REGFILE_DBG_X0_CHECK_EN
   logic        x0_err;
`endif

   regfile_dbg_ctrl_rv32i #(.DUMP_BUF_DEPTH(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_addr     (cmd_addr),
      .cmd_addr_end (cmd_addr_end),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_addr     (rsp_addr),
      .rsp_data     (rsp_data),
      .rsp_last     (rsp_last),
      .busy         (busy),
      .rf_rdwrite   (rf_rdwrite),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_in     (rf_rd_in),
      .rf_rs1_addr  (rf_rs1_addr),
      .rf_rs2_addr  (rf_rs2_addr),
      .rf_rs1       (rf_rs1),
      .rf_rs2       (rf_rs2)
`ifdef REGFILE_DBG_X0_CHECK_EN
      ,
      .x0_err       (x0_err)
`endif
   );

   always #5 clock = ~clock;

   // Register-file environment: write at posedge, read at negedge, x0 = 0.
   logic [31:0] rf [32];
   int          wr_cnt = 0;
   initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;

   always @(posedge clock) begin
      if (rf_rdwrite) begin
         wr_cnt <= wr_cnt + 1;
         if (rf_rd_addr != 5'd0) rf[rf_rd_addr] <= rf_rd_in;
      end
   end

   always @(negedge clock) begin
      rf_rs1 <= (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
      rf_rs2 <= (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];
   end

   // Reference model: architectural register contents as commanded by the host.
   logic [31:0] model [32];

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
   } rsp_t;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  a;
      logic [4:0]  e;
      logic [31:0] wd;
      int          mode;     // 0 ready always, 1 toggle, 2 random
      int          n_rsp;
      int          n_wr;
      logic [31:0] d0;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkvec(input logic [1:0] op, input logic [4:0] a, input logic [4:0] e,
                                  input logic [31:0] wd, input int mode, input int n,
                                  input int w, input logic [31:0] d0);
      vec_t v;
      v.op = op; v.a = a; v.e = e; v.wd = wd; v.mode = mode;
      v.n_rsp = n; v.n_wr = w; v.d0 = d0;
      return v;
   endfunction

   // Issues one command, checks every response against the model, and
   // reports response count, write pulses and first response data.
   task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] e,
                         input logic [31:0] wd, input int mode,
                         output int nrsp, output int nwr, output logic [31:0] first_data);
      rsp_t expq[$];
      rsp_t r, snap;
      int   ai, ei, cyc, wr0, nexp;
      bit   done, stalled;
      ai = int'(a); ei = int'(e);
      case (op)
         2'b00: begin
            r.addr = a; r.data = (a == 5'd0) ? 32'd0 : wd; r.last = 1'b1;
            expq.push_back(r);
            if (a != 5'd0) model[a] = wd;
         end
         2'b01: begin
            r.addr = a; r.data = model[a]; r.last = 1'b1;
            expq.push_back(r);
         end
         2'b10: begin
            if (ei < ai) ei = ai;
            for (int i = ai; i <= ei; i++) begin
               r.addr = 5'(i); r.data = model[i]; r.last = (i == ei);
               expq.push_back(r);
            end
         end
         default: begin
            for (int i = 1; i < 32; i++) model[i] = 32'd0;
            r.addr = 5'd31; r.data = 32'd0; r.last = 1'b1;
            expq.push_back(r);
         end
      endcase
      nexp = expq.size();
      nrsp = 0; nwr = 0; first_data = 32'hxxxxxxxx;

      cyc = 0;
      while (!cmd_ready && cyc < 50) begin
         @(posedge clock); #1; cyc++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
         return;
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_addr_end = e; cmd_wdata = wd;
      wr0 = wr_cnt;
      @(posedge clock); #1;
      cmd_valid = 1'b0;

      done = 0; stalled = 0; cyc = 0; snap = '0;
      while (!done && cyc < 400) begin
         case (mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = cyc[0];
            default: rsp_ready = 1'($urandom_range(0, 1));
         endcase
         if (stalled) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_addr", 32'(rsp_addr), 32'(snap.addr));
            chk("stall_data", rsp_data, snap.data);
            chk("stall_last", 32'(rsp_last), 32'(snap.last));
         end
         if (rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
               chk("extra_rsp", 32'(rsp_addr), 32'hFFFF_FFFF);
               done = 1;
            end else begin
               r = expq.pop_front();
               if (nrsp == 0) first_data = rsp_data;
               chk("rsp_addr", 32'(rsp_addr), 32'(r.addr));
               chk("rsp_data", rsp_data, r.data);
               chk("rsp_last", 32'(rsp_last), 32'(r.last));
               nrsp++;
               if (rsp_last) done = 1;
            end
         end
         stalled = rsp_valid && !rsp_ready;
         snap.addr = rsp_addr; snap.data = rsp_data; snap.last = rsp_last;
         @(posedge clock); #1; cyc++;
      end
      rsp_ready = 1'b0;
      if (!done) chk("rsp_timeout", 32'(done), 32'd1);
      chk("rsp_count", 32'(nrsp), 32'(nexp));
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      nwr = wr_cnt - wr0;
   endtask

   vec_t        vecs [16];
   int          nrsp, nwr, cyc;
   logic [31:0] d0;

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      vecs[0]  = mkvec(2'b00, 5'd1,  5'd0,  32'h11,       0, 1,  1,  32'h11);
      vecs[1]  = mkvec(2'b00, 5'd2,  5'd0,  32'h22,       0, 1,  1,  32'h22);
      vecs[2]  = mkvec(2'b01, 5'd1,  5'd0,  32'h0,        0, 1,  0,  32'h11);
      vecs[3]  = mkvec(2'b01, 5'd2,  5'd0,  32'h0,        1, 1,  0,  32'h22);
      vecs[4]  = mkvec(2'b00, 5'd0,  5'd0,  32'hDEADBEEF, 0, 1,  0,  32'h0);
      vecs[5]  = mkvec(2'b01, 5'd0,  5'd0,  32'h0,        0, 1,  0,  32'h0);
      vecs[6]  = mkvec(2'b00, 5'd3,  5'd0,  32'h33,       0, 1,  1,  32'h33);
      vecs[7]  = mkvec(2'b00, 5'd4,  5'd0,  32'h44,       0, 1,  1,  32'h44);
      vecs[8]  = mkvec(2'b10, 5'd0,  5'd9,  32'h0,        0, 10, 0,  32'h0);
      vecs[9]  = mkvec(2'b10, 5'd5,  5'd5,  32'h0,        0, 1,  0,  32'h0);
      vecs[10] = mkvec(2'b10, 5'd7,  5'd3,  32'h0,        0, 1,  0,  32'h0);
      vecs[11] = mkvec(2'b10, 5'd1,  5'd3,  32'h0,        2, 3,  0,  32'h11);
      vecs[12] = mkvec(2'b10, 5'd31, 5'd31, 32'h0,        0, 1,  0,  32'h0);
      vecs[13] = mkvec(2'b10, 5'd0,  5'd31, 32'h0,        1, 32, 0,  32'h0);
      vecs[14] = mkvec(2'b11, 5'd0,  5'd0,  32'h0,        0, 1,  31, 32'h0);
      vecs[15] = mkvec(2'b10, 5'd0,  5'd31, 32'h0,        2, 32, 0,  32'h0);

      // Reset state, sampled while reset is held.
      #12;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rf_rdwrite", 32'(rf_rdwrite), 32'd0);
      chk("rst_rs1_addr", 32'(rf_rs1_addr), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      #10 reset = 1'b0;
      @(posedge clock); #1;

      // Directed table.
      for (int k = 0; k < 16; k++) begin
         do_cmd(vecs[k].op, vecs[k].a, vecs[k].e, vecs[k].wd, vecs[k].mode, nrsp, nwr, d0);
         chk($sformatf("vec%0d_nrsp", k), 32'(nrsp), 32'(vecs[k].n_rsp));
         chk($sformatf("vec%0d_nwr", k), 32'(nwr), 32'(vecs[k].n_wr));
         chk($sformatf("vec%0d_d0", k), d0, vecs[k].d0);
      end

      // Randomized commands against the model.
      for (int k = 0; k < 40; k++) begin
         do_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                $urandom, int'($urandom_range(0, 2)), nrsp, nwr, d0);
      end

      // Reset in the middle of CLEAR, while rd_addr = 10.
      for (int i = 1; i < 32; i++)
         do_cmd(2'b00, 5'(i), 5'd0, 32'hA500_0000 | 32'(i), 0, nrsp, nwr, d0);
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 5'd0; cmd_addr_end = 5'd0;
      nwr = wr_cnt;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      cyc = 0;
      while (!(rf_rdwrite && rf_rd_addr == 5'd10) && cyc < 60) begin
         @(posedge clock); #1; cyc++;
      end
      chk("clr_reach_10", 32'(rf_rd_addr), 32'd10);
      #2 reset = 1'b1;
      #1;
      chk("midclr_rdwrite", 32'(rf_rdwrite), 32'd0);
      chk("midclr_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midclr_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clock); #4;
      reset = 1'b0;
      chk("midclr_wr_pulses", 32'(wr_cnt - nwr), 32'd9);
      for (int i = 1; i < 10; i++) model[i] = 32'd0;
      @(posedge clock); #1;
      do_cmd(2'b10, 5'd0, 5'd31, 32'h0, 0, nrsp, nwr, d0);
      chk("midclr_dump_n", 32'(nrsp), 32'd32);
      do_cmd(2'b01, 5'd10, 5'd0, 32'h0, 0, nrsp, nwr, d0);
      chk("midclr_x10", d0, 32'hA500_000A);

`ifdef REGFILE_DBG_X0_CHECK_EN
      chk("x0_err", 32'(x0_err), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/regfile_dbg_ctrl_rv32i.md
Name: regfile_dbg_ctrl_rv32i

Overview:
- Debug-side initiator for the RV32I 32x32 register file (write @posedge, read @negedge, x0 hard-wired 0).
- Accepts host commands over a valid/ready channel: single write, single read, range dump, clear x1..x31.
- Sequences the register-file ports and returns read data over a valid/ready response stream.
- Sits between the debug/test host and the register-file port mux; the regfile is owned while busy=1.

Parameters:
- DUMP_BUF_DEPTH, 2, response buffer entries (fixed at 2; one rs1/rs2 pair per read cycle).

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 WRITE, 01 READ, 10 DUMP, 11 CLEAR.
- cmd_addr  in  5  target register / dump start.
- cmd_addr_end  in  5  dump end, inclusive (DUMP only).
- cmd_wdata  in  32  write data (WRITE only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_addr  out  5  register index of response.
- rsp_data  out  32  register value / write echo.
- rsp_last  out  1  final response of current command.
- busy  out  1  command in progress (cmd_ready=0).
- rf_rdwrite  out  1  regfile write enable.
- rf_rd_addr  out  5  regfile write address.
- rf_rd_in  out  32  regfile write data.
- rf_rs1_addr  out  5  read address port 1.
- rf_rs2_addr  out  5  read address port 2.
- rf_rs1  in  32  read data port 1.
- rf_rs2  in  32  read data port 2.

Behaviour:
- Reset (async): state IDLE, all outputs 0 except cmd_ready=1, buffer emptied. Reset mid-operation aborts the command; rf_rdwrite drops immediately; writes already committed remain.
- States: IDLE, WR, RD, DUMP_RD, DUMP_DRAIN, CLR, RSP.
- Handshakes: transfer when valid&ready at posedge. cmd_ready=1 only in IDLE. rsp_* held stable while rsp_valid=1 and rsp_ready=0.
- WRITE: accept in cycle 0. Cycle 1 (WR): rf_rdwrite=1, rf_rd_addr=cmd_addr, rf_rd_in=cmd_wdata. cmd_addr=0: rf_rdwrite stays 0, flow unchanged. Cycle 2 (RSP): rsp_valid, rsp_addr=addr, rsp_data=wdata (0 if addr 0), rsp_last=1.
- READ: cycle 1 (RD): rf_rs1_addr=addr; rf_rs1 is captured at the posedge ending cycle 1 (valid after negedge). Cycle 2: rsp_valid with captured data, rsp_last=1.
- DUMP: range start..end inclusive; end<start is treated as end=start.
  - DUMP_RD drives rs1=a, rs2=a+1 and captures both into the buffer in one cycle. If only one register remains, rs2=rs1 and one entry is captured.
  - DUMP_DRAIN emits the buffer in address order. The next pair is issued only when the buffer is empty; no rsp bubble is required on drain.
  - rsp_last=1 on the end-address entry. Range 0..31 gives 32 responses in 16 read cycles. Address increment never wraps past 31.
- CLEAR: 31 consecutive cycles with rf_rdwrite=1, rd_addr 1..31, rd_in=0. Then one response with rsp_addr=31, rsp_data=0, rsp_last=1.
- After the rsp_last transfer, return to IDLE; cmd_ready=1 on the following cycle.
- rf_rdwrite is never high outside WR/CLR. Read address outputs hold their last value when unused.

Optional Feature:
- Macro REGFILE_DBG_X0_CHECK_EN.
- Enabled: adds output x0_err (1 bit, reset 0, sticky until reset). It sets when any captured read of address 0 returns nonzero; the response still returns the raw value.
- Disabled: no x0_err port and no check logic.

Decomposition:
- Shared package/header: cmd_op encodings (OP_WRITE, OP_READ, OP_DUMP, OP_CLEAR), state encodings, XLEN=32, REG_AW=5, NUM_REGS=32.
- One natural sub-module: regfile_dbg_rspbuf, a 2-entry in-order response buffer with a valid/ready output and a 2-wide load.

Test Plan:
- WRITE x1=0x11, x2=0x22, then READ x1/x2: responses 0x11/0x22, rsp_last=1, one rf_rdwrite pulse per write.
- WRITE x0=0xDEADBEEF: rf_rdwrite never asserts, echo rsp_data=0. READ x0 returns 0; x0_err stays 0 when enabled.
- DUMP 0..9 after writing x1..x4=0x11..0x44: ten responses 0,0x11,0x22,0x33,0x44,0,0,0,0,0, with rsp_last only on addr 9.
- DUMP 5..5 and DUMP 7..3: a single response each (addr 5, addr 7), both with rsp_last=1.
- DUMP 0..31 with rsp_ready toggling 1/0: all 32 in order, rsp fields stable while stalled, no loss or duplication.
- CLEAR after writes, then DUMP 0..31: all zero. Reset asserted mid-CLEAR at rd_addr=10: rf_rdwrite drops immediately; x1..x9 zero, x10.. retain old values.
